// File: rtl/pe_unroll_kernel_ctrl_pkg.sv
// Shared definitions for the unrolled-kernel PE controller: state encoding and
// counter width helpers.
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_WIN = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } ctrl_state_t;

  // Width of an index counter that runs 0..n-1 (never narrower than one bit).
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must be able to hold the value n itself (0..n).
  function automatic int countWidth(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/pe_unroll_kernel_ctrl_credit_counter.sv
// Downstream credit tracker. Starts full, drops by one per consumed slot and
// rises by one per returned word. A return while already full is dropped and
// flagged, since the downstream buffer cannot hold more than MAX words.
module credit_counter
  import pe_ctrl_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       consume,
  input  logic                       ret,
  output logic [countWidth(MAX)-1:0] count,
  output logic                       overflow_err
);

  localparam int CW = countWidth(MAX);
  localparam logic [CW-1:0] FULL = CW'(MAX);

  logic [CW-1:0] r_count;
  logic          w_take;
  logic          w_retOk;

  assign w_take       = consume && (r_count != '0);
  assign w_retOk      = ret && (r_count != FULL);
  assign overflow_err = ret && (r_count == FULL);
  assign count        = r_count;

  // Credit register: simultaneous take and return cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= FULL;
    end else if (w_take && !w_retOk) begin
      r_count <= r_count - CW'(1);
    end else if (!w_take && w_retOk) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/pe_unroll_kernel_ctrl.sv
// Sequencer for one unrolled-kernel PE datapath: accepts im2col windows,
// issues data_latch and the IN*OUT-cycle cnt_en burst per window, throttles
// each output channel against downstream credits and reports frame completion.
module pe_unroll_kernel_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int IN_CHANNEL  = 16,
  parameter int OUT_CHANNEL = 32,
  parameter int NUM_WINDOWS = 1024,
  parameter int OUT_CREDITS = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               weights_ready,
  input  logic                               win_valid,
  output logic                               win_ready,
  output logic                               dp_data_latch,
  output logic                               dp_cnt_en,
  input  logic                               dp_cnt_limit,
  input  logic                               dp_o_valid,
  input  logic                               out_pop,
  output logic [$clog2(OUT_CREDITS+1)-1:0]   credit_cnt,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               seq_err
);

  localparam int IC_W  = idxWidth(IN_CHANNEL);
  localparam int OC_W  = idxWidth(OUT_CHANNEL);
  localparam int WC_W  = idxWidth(NUM_WINDOWS);
  localparam int OUT_W = countWidth(NUM_WINDOWS * OUT_CHANNEL);

  localparam logic [IC_W-1:0]  IC_LAST   = IC_W'(IN_CHANNEL - 1);
  localparam logic [OC_W-1:0]  OC_LAST   = OC_W'(OUT_CHANNEL - 1);
  localparam logic [WC_W-1:0]  WC_LAST   = WC_W'(NUM_WINDOWS - 1);
  localparam logic [OUT_W-1:0] OUT_TOTAL = OUT_W'(NUM_WINDOWS * OUT_CHANNEL);

  ctrl_state_t       r_state;
  ctrl_state_t       w_nextState;
  logic [IC_W-1:0]   r_ic;
  logic [OC_W-1:0]   r_oc;
  logic [WC_W-1:0]   r_winCnt;
  logic [OUT_W-1:0]  r_outCnt;
  logic              r_seqErr;
  logic              r_wrPrev;

  logic              w_winReady;
  logic              w_cntEn;
  logic              w_frameDone;
  logic              w_winAccept;
  logic              w_frameAccept;
  logic              w_lastPos;
  logic              w_winLast;
  logic              w_consume;
  logic              w_creditErr;
  logic              w_errEvent;

  assign w_winAccept   = win_valid && w_winReady;
  assign w_frameAccept = (r_state == IDLE) && start && weights_ready;
  assign w_lastPos     = (r_ic == IC_LAST) && (r_oc == OC_LAST);
  assign w_winLast     = w_cntEn && w_lastPos;
  assign w_consume     = w_cntEn && (r_ic == '0);

  assign w_errEvent = ((r_state == IDLE) && start && !weights_ready)
                    || (w_winLast && !dp_cnt_limit)
                    || (w_cntEn && !w_lastPos && dp_cnt_limit)
                    || w_creditErr
                    || (r_wrPrev && !weights_ready && busy);

  assign win_ready     = w_winReady;
  assign dp_data_latch = w_winAccept;
  assign dp_cnt_en     = w_cntEn;
  assign frame_done    = w_frameDone;
  assign busy          = (r_state != IDLE);
  assign seq_err       = r_seqErr;

  credit_counter #(
    .MAX(OUT_CREDITS)
  ) u_credit (
    .clk         (clk),
    .rst         (rst),
    .consume     (w_consume),
    .ret         (out_pop),
    .count       (credit_cnt),
    .overflow_err(w_creditErr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus the strobes decoded from registered state and counters;
  // a RUN cycle at the start of an output channel stalls when no credit is free.
  always_comb begin
    w_nextState = r_state;
    w_winReady  = 1'b0;
    w_cntEn     = 1'b0;
    w_frameDone = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && weights_ready) begin
          w_nextState = WAIT_WIN;
        end
      end
      WAIT_WIN: begin
        w_winReady = (credit_cnt != '0);
        if (win_valid && w_winReady) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_cntEn = !((r_ic == '0) && (credit_cnt == '0));
        if (w_cntEn && w_lastPos) begin
          w_nextState = (r_winCnt == WC_LAST) ? DRAIN : WAIT_WIN;
        end
      end
      DRAIN: begin
        if (r_outCnt == OUT_TOTAL) begin
          w_frameDone = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Input/output channel indices: cleared on window accept, stepped per cnt_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ic <= '0;
      r_oc <= '0;
    end else if (w_winAccept) begin
      r_ic <= '0;
      r_oc <= '0;
    end else if (w_cntEn) begin
      if (r_ic == IC_LAST) begin
        r_ic <= '0;
        r_oc <= (r_oc == OC_LAST) ? '0 : r_oc + OC_W'(1);
      end else begin
        r_ic <= r_ic + IC_W'(1);
      end
    end
  end

  // Window counter: one step per completed window, restarted per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_winCnt <= '0;
    end else if (w_frameAccept) begin
      r_winCnt <= '0;
    end else if (w_winLast) begin
      r_winCnt <= (r_winCnt == WC_LAST) ? '0 : r_winCnt + WC_W'(1);
    end
  end

  // Datapath output counter: counts o_valid in any state, saturating at the frame total.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outCnt <= '0;
    end else if (w_frameAccept) begin
      r_outCnt <= '0;
    end else if (dp_o_valid && (r_outCnt != OUT_TOTAL)) begin
      r_outCnt <= r_outCnt + OUT_W'(1);
    end
  end

  // Sticky sequencing error plus the previous weights_ready level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seqErr <= 1'b0;
      r_wrPrev <= 1'b0;
    end else begin
      r_wrPrev <= weights_ready;
      if (w_errEvent) begin
        r_seqErr <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pe_unroll_kernel_ctrl.md
# pe_unroll_kernel_ctrl

Sequencer for the unrolled-kernel PE datapath. Accepts im2col windows from the line buffer over a valid/ready handshake, issues the single-cycle `data_latch` and the `IN_CHANNEL*OUT_CHANNEL`-cycle `cnt_en` burst for each window, and throttles per output channel against downstream buffer credits. It also counts datapath outputs and reports frame completion. It sits between the line-buffer/window generator and one datapath instance.

## Interface
- `IN_CHANNEL`, 16, input channels per window; must match the datapath.
- `OUT_CHANNEL`, 32, output channels per window; must match the datapath.
- `NUM_WINDOWS`, 1024, windows per frame (≥1).
- `OUT_CREDITS`, 4, downstream output-buffer depth in words (≥1).

Ports:
- `clk` input 1: single clock. All logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a frame. Ignored while `busy`.
- `weights_ready` input 1: level; high when all kernel, bias and BN words are loaded.
- `win_valid` input 1: window present on the datapath `i_data` bus.
- `win_ready` output 1: controller accepts a window.
- `dp_data_latch` output 1: datapath `data_latch`; equals `win_valid & win_ready`.
- `dp_cnt_en` output 1: datapath `cnt_en`.
- `dp_cnt_limit` input 1: datapath `cnt_limit`.
- `dp_o_valid` input 1: datapath `o_valid`.
- `out_pop` input 1: downstream consumed one output word; returns one credit.
- `credit_cnt` output `$clog2(OUT_CREDITS+1)`: current free credits.
- `busy` output 1: high from `start` acceptance until `frame_done`.
- `frame_done` output 1: one-cycle pulse when the frame's last output is seen.
- `seq_err` output 1: sticky error flag; cleared only by `rst`.

## Operation
- States: IDLE, WAIT_WIN, RUN, DRAIN.
- Counters:
  - `ic` counts 0..IN_CHANNEL-1.
  - `oc` counts 0..OUT_CHANNEL-1.
  - `win_cnt` counts 0..NUM_WINDOWS-1.
  - `out_cnt` counts 0..NUM_WINDOWS*OUT_CHANNEL.
- IDLE:
  - `start & weights_ready` → WAIT_WIN. Clear `win_cnt` and `out_cnt`; set `busy`.
  - `start & ~weights_ready` → stay in IDLE and set `seq_err`.
- WAIT_WIN:
  - `win_ready` = 1 when `credit_cnt`≥1.
  - Handshake → RUN with `ic`=`oc`=0.
- RUN:
  - `dp_cnt_en` = 1 except when `ic`==0 and `credit_cnt`==0. In that case stall with `cnt_en`=0 and hold all counters.
  - Each `cnt_en` cycle with `ic`==0 consumes one credit.
  - `ic` wraps at IN_CHANNEL-1; on the wrap, `oc` increments.
- End of window: `cnt_en` with `ic`==IN-1 and `oc`==OUT-1.
  - `dp_cnt_limit` must be 1 in that cycle; otherwise set `seq_err`.
  - `dp_cnt_limit`=1 in any other `cnt_en` cycle also sets `seq_err`.
  - Then `win_cnt`++. If `win_cnt` was NUM_WINDOWS-1 → DRAIN, else → WAIT_WIN.
- DRAIN:
  - Stay until `out_cnt` reaches NUM_WINDOWS*OUT_CHANNEL.
  - Then pulse `frame_done`, clear `busy`, → IDLE.
- `out_cnt` increments on every `dp_o_valid`, in any state.
- Credits:
  - Consume and `out_pop` in the same cycle → `credit_cnt` unchanged.
  - `out_pop` with `credit_cnt`==OUT_CREDITS → ignored and sets `seq_err`.
- `weights_ready` falling while `busy` sets `seq_err`. The sequence continues.

## Timing
- Reset values:
  - state IDLE; all counters 0.
  - `credit_cnt`=OUT_CREDITS.
  - `win_ready`, `dp_data_latch`, `dp_cnt_en`, `busy`, `frame_done`, `seq_err` = 0.
- `win_ready`, `dp_cnt_en` and `frame_done` are decoded from registered state and counters. `dp_data_latch` is a combinational AND.
- First `dp_cnt_en` is in the cycle after `dp_data_latch`.
- Next `dp_data_latch` is earliest in the cycle after the window's last `cnt_en`. This one-cycle gap is mandatory: the MACC samples the input register one cycle after `cnt_en`.
- Unstalled window: 1 latch cycle + IN*OUT `cnt_en` cycles. Minimum per-window period: 1 + IN*OUT cycles.
- `frame_done` is asserted in the cycle after the `dp_o_valid` that makes `out_cnt` reach its final value.
- `rst` mid-frame returns all state and counters to their reset values in the next cycle. The datapath's own `rst_n` is driven from the same source.

## Structure
- Shared package `pe_ctrl_pkg` holds:
  - state encoding constants (IDLE=0, WAIT_WIN=1, RUN=2, DRAIN=3);
  - width helpers for `ic`, `oc`, `win_cnt` and `out_cnt`.
- One sub-module, `credit_counter`: parameter `MAX`; ports `consume`, `ret`, `count`, `overflow_err`, with the same synchronous reset to `MAX`.

## Test plan
- IN=2, OUT=3, NUM_WINDOWS=2, CREDITS=8, `out_pop` tied to `dp_o_valid`, window always valid:
  - `dp_data_latch` at cycles t and t+7;
  - 6 `cnt_en` cycles per window;
  - `frame_done` once after the 6th `dp_o_valid`.
- CREDITS=1 with `out_pop` delayed 10 cycles after each output: `dp_cnt_en` stalls at every `ic`==0 boundary, `credit_cnt` never goes below 0, and outputs are not lost.
- `win_valid` low for 5 cycles in WAIT_WIN: `dp_cnt_en` stays 0 and `dp_data_latch` fires on the first valid cycle.
- `start` while `busy`, and `start` with `weights_ready`=0:
  - the first is ignored;
  - the second sets `seq_err` and leaves `busy` 0.
- `dp_cnt_limit` forced high at `ic`=0, `oc`=0: `seq_err`=1 and stays 1 until `rst`.
- `rst` asserted mid-RUN: next cycle `dp_cnt_en`=0, `credit_cnt`=OUT_CREDITS, state IDLE; a new `start` then completes a normal frame.
